// File: rtl/serial_word_collector_if.sv
// Output handshake bundle of the serial word collector.
// Producer drives Word/Word_valid, consumer drives Word_ready.
interface serial_word_collector_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] Word;
    logic             Word_valid;
    logic             Word_ready;

    modport master (
        output Word,
        output Word_valid,
        input  Word_ready
    );

    modport slave (
        input  Word,
        input  Word_valid,
        output Word_ready
    );
endinterface

// File: rtl/serial_word_collector.sv
// Deserialises an LSB-first, Start-framed bit stream into WIDTH-bit words.
// One-word output slot with valid/ready and a sticky overrun flag.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     Data,
    input  logic                     Start,
    serial_word_collector_if.master  bus,
    output logic                     Busy,
    output logic                     Overrun,
    input  logic                     Clear_ovr
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done;
    logic             slot_free;

    assign Busy      = (state_q == SHIFT);
    assign slot_free = !bus.Word_valid || bus.Word_ready;

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, shift/count update and frame completion
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    sr_d    = {Data, sr_q[WIDTH-1:1]};
                    cnt_d   = ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = {Data, sr_q[WIDTH-1:1]};
                if (Start) begin
                    // A new frame discards the partial one.
                    cnt_d = ONE;
                end else if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, counter, output slot and overrun flag
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sr_q           <= '0;
            cnt_q          <= '0;
            bus.Word       <= '0;
            bus.Word_valid <= 1'b0;
            Overrun        <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            if (done && slot_free) begin
                bus.Word       <= sr_d;
                bus.Word_valid <= 1'b1;
            end else if (bus.Word_valid && bus.Word_ready) begin
                bus.Word_valid <= 1'b0;
            end
            // A drop on the same edge as a clear keeps the flag set.
            if (done && !slot_free) begin
                Overrun <= 1'b1;
            end else if (Clear_ovr) begin
                Overrun <= 1'b0;
            end
        end
    end
endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the serial two's-complement converter.
- Takes the converter's LSB-first serial output bit stream, framed by a Start strobe, and deserialises it into a WIDTH-bit parallel word.
- Presents the word on a valid/ready handshake, with a sticky overrun flag for words lost to backpressure.

Parameters:
- WIDTH, 8, bits per serial frame and width of the parallel output word; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- Data  input  1  serial bit from the converter's Output; sampled every rising edge; LSB first.
- Start  input  1  high in the cycle Data carries bit 0 of a frame.
- Word  output  WIDTH  assembled word, bit 0 = first serial bit received.
- Word_valid  output  1  Word holds an unconsumed word.
- Word_ready  input  1  consumer accepts Word when Word_valid && Word_ready at a rising edge.
- Busy  output  1  frame in progress (state SHIFT).
- Overrun  output  1  sticky: a completed word was dropped because the output slot was full.
- Clear_ovr  input  1  synchronous clear of Overrun.

Behaviour:
- Reset (n_reset low, asynchronous): state IDLE, shift register 0, bit counter 0, Word 0, Word_valid 0, Busy 0, Overrun 0. Release takes effect at the next rising edge.
- Shift register shifts right: sr <= {Data, sr[WIDTH-1:1]}. After WIDTH captures, the first bit received is at sr[0].
- Counter width is clog2(WIDTH).
- FSM IDLE:
  - Start=1 → capture Data as bit 0, cnt <= 1, go SHIFT.
  - Start=0 → hold; Data is ignored.
- FSM SHIFT:
  - Each edge captures Data and increments cnt.
  - Completion: the edge that captures bit WIDTH-1 (cnt == WIDTH-1) completes the frame; the FSM returns to IDLE.
  - Start=1 in SHIFT, including the last-bit cycle, restarts the frame. The current Data is taken as bit 0, cnt <= 1, the FSM stays in SHIFT, and the partial frame is discarded silently.
- Busy = (state == SHIFT).
- Frame latency: with Start sampled at edge k, Word/Word_valid update at edge k+WIDTH-1 and are visible from then on.
- Output slot on completion:
  - Slot free (Word_valid==0, or Word_valid && Word_ready at the same edge) → Word <= assembled word, Word_valid <= 1.
  - Otherwise the new word is dropped, Word/Word_valid are unchanged, Overrun <= 1.
- Consumption: Word_valid && Word_ready without a simultaneous completion → Word_valid <= 0. Word retains its last value.
- Word is stable whenever Word_valid=1 and no handshake occurs.
- Back-to-back frames: Start may be asserted in the cycle immediately after the completing edge (FSM already IDLE), giving zero bubble beyond the completing cycle.
- Overrun is set on drop and cleared by Clear_ovr. If set and clear occur at the same edge, set wins.
- Word_ready while Word_valid=0 has no effect.

Test Plan (WIDTH=8):
- Basic frame: after reset release, Start at edge k with serial bits 0,0,1,0,1,1,0,1 (0xB4 LSB first), Word_ready=0 → Word=0xB4, Word_valid=1 from edge k+7; Busy high edges k..k+6, low after k+7; Word held for 20 cycles.
- Chained with converter: feed 0x0C LSB first into the two's-complement stage, its Output → Data, Start aligned to bit 0 → Word=0xF4 (-12).
- Restart: Start, 4 bits of 0xFF, Start again, then frame 0x35 → single Word=0x35; no Overrun; Word_valid rises exactly 7 edges after the second Start.
- Backpressure/overrun: frame 0x11 completes, Word_ready=0, frame 0x22 completes → Word stays 0x11, Overrun=1. Pulse Word_ready → Word_valid=0. Clear_ovr → Overrun=0. Third frame 0x33 → Word=0x33, Overrun stays 0.
- Simultaneous: Word_valid=1 (0x44) with Word_ready=1 at the same edge frame 0x55 completes → Word=0x55, Word_valid stays 1, Overrun=0. Back-to-back frames (Start one cycle after completion) are both delivered with Word_ready tied high.
- Reset mid-frame: drop n_reset asynchronously after 3 bits of a frame → Busy, Word_valid, Word, Overrun all 0 immediately. After release, a fresh frame 0xA5 → Word=0xA5 with no residue from the aborted frame.
